// File: rtl/execution_sequencer.sv
// Multi-cycle phase controller: steps each instruction through fetch, decode,
// execute, an optional memory or I/O wait, and writeback, emitting one-cycle gating strobes.
module execution_sequencer #(
  parameter int MEM_WAIT_CYCLES = 1,
  parameter int COUNT_WIDTH     = 32,
  parameter int WAIT_WIDTH      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   is_input,
  input  logic                   is_output,
  input  logic                   is_memory_access,
  input  logic                   confirm_button,
  output logic                   fetch_strobe,
  output logic                   pc_update,
  output logic                   register_write_gate,
  output logic                   memory_write_gate,
  output logic                   io_waiting,
  output logic                   halted,
  output logic [2:0]             phase,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  typedef enum logic [2:0] {
    FETCH      = 3'd0,
    FETCH_WAIT = 3'd1,
    DECODE     = 3'd2,
    EXECUTE    = 3'd3,
    MEM_WAIT   = 3'd4,
    IO_WAIT    = 3'd5,
    WRITEBACK  = 3'd6,
    HALT       = 3'd7
  } state_e;

  localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(MEM_WAIT_CYCLES);

  state_e                 state_q;
  logic [WAIT_WIDTH-1:0]  wait_q;
  logic                   btn_q;
  logic [COUNT_WIDTH-1:0] retired_q;
  logic                   press;

  // Only a fresh press counts; a button held since before IO_WAIT must be released first.
  assign press = confirm_button & ~btn_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      btn_q     <= 1'b0;
      retired_q <= '0;
    end else begin
      btn_q <= confirm_button;
      unique case (state_q)
        FETCH: begin
          wait_q  <= WAIT_LOAD;
          state_q <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (wait_q == '0) state_q <= DECODE;
          else              wait_q  <= wait_q - WAIT_WIDTH'(1);
        end
        DECODE: state_q <= enable ? EXECUTE : HALT;
        EXECUTE: begin
          if (is_input || is_output) begin
            state_q <= IO_WAIT;
          end else if (is_memory_access) begin
            wait_q  <= WAIT_LOAD;
            state_q <= MEM_WAIT;
          end else begin
            state_q <= WRITEBACK;
          end
        end
        MEM_WAIT: begin
          if (wait_q == '0) state_q <= WRITEBACK;
          else              wait_q  <= wait_q - WAIT_WIDTH'(1);
        end
        IO_WAIT: begin
          if (press) state_q <= WRITEBACK;
        end
        WRITEBACK: begin
          retired_q <= retired_q + COUNT_WIDTH'(1);
          state_q   <= FETCH;
        end
        HALT: state_q <= HALT;
      endcase
    end
  end

  // Strobes decode registered state only; reset masks them in the same cycle it is raised.
  always_comb begin
    fetch_strobe        = 1'b0;
    pc_update           = 1'b0;
    register_write_gate = 1'b0;
    memory_write_gate   = 1'b0;
    io_waiting          = 1'b0;
    halted              = 1'b0;
    if (!reset) begin
      fetch_strobe        = (state_q == FETCH_WAIT) && (wait_q == '0);
      memory_write_gate   = (state_q == MEM_WAIT) && (wait_q == WAIT_LOAD);
      register_write_gate = (state_q == WRITEBACK);
      pc_update           = (state_q == WRITEBACK);
      io_waiting          = (state_q == IO_WAIT);
      halted              = (state_q == HALT);
    end
  end

  assign phase         = state_q;
  assign retired_count = retired_q;

endmodule
